mux8_rr_arbiter: RTL and testbench

Round-robin arbiter and select sequencer for the shared 8-to-1 single-bit multiplexer (inputs d0..d7, selects s2/s1/s0, output y). Up to eight requesters compete for the mux output. The block grants one requester at a time and drives s2/s1/s0 to route that requester's data input to y. It holds the grant until the requester releases or a hold limit expires, and it inserts a one-cycle dead gap on every handover.

---
 rtl/mux8_rr_arbiter_if.sv | 21 ++
 rtl/mux8_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux8_rr_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// Bus between the requesters and the round-robin arbiter for the shared 8-to-1 mux.
// The requesters (master) drive req. The arbiter (slave) drives the grant and the mux selects.
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       s2;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  gnt, s2, s1, s0, busy, timeout
    );

    modport slave (
        input  req,
        output gnt, s2, s1, s0, busy, timeout
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 8-to-1 mux.
// A grant lasts until its owner releases or it has run MAX_HOLD cycles, and a one-cycle gap follows every grant.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    mux8_rr_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;
    logic [7:0] cnt;
    logic [2:0] ptr;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;

    // Search starts one past the last winner, so the last winner is always checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 8'h00;
            sel     <= 3'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= 8'd0;
            ptr     <= 3'd7;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (win_found) begin
                        state <= GRANT;
                        gnt   <= 8'(1) << win_idx;
                        sel   <= win_idx;
                        ptr   <= win_idx;
                        cnt   <= 8'd0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        gnt   <= 8'h00;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // A release wins over an expiry in the same cycle, so no timeout is reported then.
                    if (!bus.req[ptr]) begin
                        state <= GAP;
                        gnt   <= 8'h00;
                        busy  <= 1'b1;
                    end else if (cnt == HOLD_LAST) begin
                        state   <= GAP;
                        gnt     <= 8'h00;
                        busy    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 8'h00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.s2      = sel[2];
    assign bus.s1      = sel[1];
    assign bus.s0      = sel[0];
    assign bus.busy    = busy;
    assign bus.timeout = timeout;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed checks of the round-robin mux arbiter on three instances with hold limits of 16, 2 and 4.
// Expected grants, selects and pulses are worked out by hand for each vector.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad = 0;
    logic [7:0] dvec = 8'h04;
    logic [12:0] inv_v;

    mux8_rr_arbiter_if ifa ();
    mux8_rr_arbiter_if ifb ();
    mux8_rr_arbiter_if ifc ();

    mux8_rr_arbiter #(.MAX_HOLD(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mux8_rr_arbiter #(.MAX_HOLD(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));
    mux8_rr_arbiter #(.MAX_HOLD(4))  dut_c (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The packed snapshot is {gnt[7:0], s2, s1, s0, busy, timeout}.
    function automatic logic [12:0] snap(input int u);
        case (u)
            0:       snap = {ifa.gnt, ifa.s2, ifa.s1, ifa.s0, ifa.busy, ifa.timeout};
            1:       snap = {ifb.gnt, ifb.s2, ifb.s1, ifb.s0, ifb.busy, ifb.timeout};
            default: snap = {ifc.gnt, ifc.s2, ifc.s1, ifc.s0, ifc.busy, ifc.timeout};
        endcase
    endfunction

    function automatic logic muxY(input logic [7:0] d, input logic [2:0] s);
        return d[s];
    endfunction

    task automatic applyStimulus(input int u, input logic [7:0] r);
        case (u)
            0:       ifa.req = r;
            1:       ifb.req = r;
            default: ifc.req = r;
        endcase
    endtask

    task automatic checkUnit(input string tag, input int u, input logic [7:0] eg,
                             input logic [2:0] es, input logic eb, input logic et);
        logic [12:0] v;
        v = snap(u);
        checkOutput({tag, ".gnt"},     32'(v[12:5]), 32'(eg));
        checkOutput({tag, ".sel"},     32'(v[4:2]),  32'(es));
        checkOutput({tag, ".busy"},    32'(v[1]),    32'(eb));
        checkOutput({tag, ".timeout"}, 32'(v[0]),    32'(et));
    endtask

    // These invariants must hold on every instance in every cycle.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            inv_v = snap(u);
            checkOutput($sformatf("inv%0d.onehot", u), 32'($onehot0(inv_v[12:5])), 32'd1);
            if (inv_v[12:5] != 8'h00) begin
                checkOutput($sformatf("inv%0d.gnt_sel", u), 32'(inv_v[5 + inv_v[4:2]]), 32'd1);
                checkOutput($sformatf("inv%0d.busy", u), 32'(inv_v[1]), 32'd1);
            end
        end
    end

    initial begin
        logic [2:0] w;
        rst = 1'b1;
        applyStimulus(0, 8'h00);
        applyStimulus(1, 8'h00);
        applyStimulus(2, 8'h00);
        repeat (2) @(negedge clk);
        checkUnit("rst_a", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        checkUnit("rst_b", 1, 8'h00, 3'd0, 1'b0, 1'b0);
        checkUnit("rst_c", 2, 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Requester 2 holds req for five cycles, then releases.
        applyStimulus(0, 8'h04);
        @(negedge clk);
        checkUnit("s1_grant", 0, 8'h04, 3'd2, 1'b1, 1'b0);
        checkOutput("s1_y", 32'(muxY(dvec, snap(0) >> 2)), 32'd1);
        repeat (4) begin
            @(negedge clk);
            checkUnit("s1_hold", 0, 8'h04, 3'd2, 1'b1, 1'b0);
        end
        applyStimulus(0, 8'h00);
        @(negedge clk);
        checkUnit("s1_gap", 0, 8'h00, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        checkUnit("s1_idle", 0, 8'h00, 3'd2, 1'b0, 1'b0);

        // With all requesters asserted and a hold limit of 2, grants rotate and every one times out.
        applyStimulus(1, 8'hFF);
        for (int k = 0; k < 9; k++) begin
            w = 3'(k);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                checkUnit($sformatf("rot%0d_hold%0d", k, c), 1, 8'(1) << w, w, 1'b1, 1'b0);
            end
            @(negedge clk);
            checkUnit($sformatf("rot%0d_gap", k), 1, 8'h00, w, 1'b1, 1'b1);
        end
        applyStimulus(1, 8'h00);
        @(negedge clk);
        checkUnit("rot_idle", 1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Requester 6 wins first. Once it times out, requester 0 wins through the wrap from 7 to 0.
        applyStimulus(2, 8'h40);
        @(negedge clk);
        checkUnit("wrap_g6", 2, 8'h40, 3'd6, 1'b1, 1'b0);
        applyStimulus(2, 8'h41);
        repeat (3) begin
            @(negedge clk);
            checkUnit("wrap_hold6", 2, 8'h40, 3'd6, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkUnit("wrap_to", 2, 8'h00, 3'd6, 1'b1, 1'b1);
        @(negedge clk);
        checkUnit("wrap_g0", 2, 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(2, 8'h00);
        @(negedge clk);
        checkUnit("wrap_gap", 2, 8'h00, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        checkUnit("wrap_idle", 2, 8'h00, 3'd0, 1'b0, 1'b0);

        // Requester 3 is the only requester, so it is re-granted after its timeout.
        applyStimulus(2, 8'h08);
        repeat (4) begin
            @(negedge clk);
            checkUnit("sole_hold", 2, 8'h08, 3'd3, 1'b1, 1'b0);
        end
        @(negedge clk);
        checkUnit("sole_to", 2, 8'h00, 3'd3, 1'b1, 1'b1);
        @(negedge clk);
        checkUnit("sole_regrant", 2, 8'h08, 3'd3, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkUnit("sole_hold2", 2, 8'h08, 3'd3, 1'b1, 1'b0);
        end
        // The owner releases in the same cycle its hold expires, so this counts as a release.
        applyStimulus(2, 8'h00);
        @(negedge clk);
        checkUnit("simul_gap", 2, 8'h00, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        checkUnit("simul_idle", 2, 8'h00, 3'd3, 1'b0, 1'b0);

        // Asynchronous reset arrives between clock edges while requester 5 holds the grant.
        applyStimulus(0, 8'h20);
        @(negedge clk);
        checkUnit("mid_g5", 0, 8'h20, 3'd5, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 checkUnit("mid_rst", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(0, 8'h21);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkUnit("mid_after", 0, 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(0, 8'h00);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
